// File: rtl/mioc_dram_arbiter.sv
// ADAM DRAM sequencer: RAS/CAS/MUX generation and Z80 / 6801 DMA sharing.
// Moore outputs are registered from the next state so they never glitch.
module mioc_dram_arbiter #(
    parameter int T_CAS     = 2,
    parameter int MAX_BURST = 8
) (
    input  logic B_PHI,
    input  logic RST_N,
    input  logic BMREQ_N,
    input  logic BRFSH_N,
    input  logic BA15,
    input  logic DMA_N,
    input  logic DMA_BANK,
    input  logic BUSAK_N,
    output logic BUSRQ_N,
    output logic ADDRBUFEN_N,
    output logic RAS_N,
    output logic CAS1_N,
    output logic CAS2_N,
    output logic MUX,
    output logic DMA_ACK,
    output logic BUSY
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_Z_RAS   = 4'd1;
    localparam logic [3:0] S_Z_CAS   = 4'd2;
    localparam logic [3:0] S_REF     = 4'd3;
    localparam logic [3:0] S_PRE     = 4'd4;
    localparam logic [3:0] S_DMA_REQ = 4'd5;
    localparam logic [3:0] S_DMA_RAS = 4'd6;
    localparam logic [3:0] S_DMA_CAS = 4'd7;
    localparam logic [3:0] S_DMA_PRE = 4'd8;
    localparam logic [3:0] S_DMA_REL = 4'd9;

    localparam logic [2:0] CYC_LAST  = 3'(T_CAS - 1);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    logic [3:0] state_q, state_d;
    logic       bank_q, bank_d;
    logic [2:0] cyc_q, cyc_d;
    logic [7:0] burst_q, burst_d;

    logic ras_d, cas1_d, cas2_d, mux_d, busrq_d, abe_d, ack_d, busy_d;
    logic ras_q, cas1_q, cas2_q, mux_q, busrq_q, abe_q, ack_q, busy_q;

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        cyc_d   = cyc_q;
        burst_d = burst_q;
        case (state_q)
            S_IDLE: begin
                if (!BMREQ_N && !BRFSH_N) begin
                    state_d = S_REF;
                end else if (!BMREQ_N) begin
                    state_d = S_Z_RAS;
                    bank_d  = BA15;
                end else if (!DMA_N) begin
                    state_d = S_DMA_REQ;
                end
            end
            S_Z_RAS: state_d = S_Z_CAS;
            S_Z_CAS: if (BMREQ_N) state_d = S_PRE;
            S_REF:   if (BMREQ_N) state_d = S_PRE;
            S_PRE:   state_d = S_IDLE;
            S_DMA_REQ: begin
                if (!BUSAK_N && !DMA_N) begin
                    state_d = S_DMA_RAS;
                    burst_d = 8'd0;
                end else if (DMA_N && BUSAK_N) begin
                    state_d = S_IDLE;
                end else if (DMA_N) begin
                    state_d = S_DMA_REL;
                end
            end
            S_DMA_RAS: begin
                state_d = S_DMA_CAS;
                bank_d  = DMA_BANK;
                cyc_d   = 3'd0;
            end
            S_DMA_CAS: begin
                if (cyc_q == CYC_LAST) state_d = S_DMA_PRE;
                else cyc_d = cyc_q + 3'd1;
            end
            S_DMA_PRE: begin
                if (burst_q != BURST_MAX) burst_d = burst_q + 8'd1;
                // a vanished grant finishes the access, then releases at once
                if (!DMA_N && !BUSAK_N && burst_d < BURST_MAX)
                    state_d = S_DMA_RAS;
                else
                    state_d = S_DMA_REL;
            end
            S_DMA_REL: if (BUSAK_N) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ras_d   = 1'b1;
        cas1_d  = 1'b1;
        cas2_d  = 1'b1;
        mux_d   = 1'b0;
        busrq_d = 1'b1;
        abe_d   = 1'b0;
        ack_d   = 1'b0;
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_Z_RAS, S_REF: ras_d = 1'b0;
            S_Z_CAS: begin
                ras_d  = 1'b0;
                mux_d  = 1'b1;
                cas1_d = bank_d;
                cas2_d = !bank_d;
            end
            S_DMA_REQ: busrq_d = 1'b0;
            S_DMA_RAS: begin
                busrq_d = 1'b0;
                abe_d   = 1'b1;
                ras_d   = 1'b0;
            end
            S_DMA_CAS: begin
                busrq_d = 1'b0;
                abe_d   = 1'b1;
                ras_d   = 1'b0;
                mux_d   = 1'b1;
                cas1_d  = bank_d;
                cas2_d  = !bank_d;
                ack_d   = (cyc_d == CYC_LAST);
            end
            S_DMA_PRE: begin
                busrq_d = 1'b0;
                abe_d   = 1'b1;
            end
            S_DMA_REL: abe_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge B_PHI) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            bank_q  <= 1'b0;
            cyc_q   <= 3'd0;
            burst_q <= 8'd0;
            ras_q   <= 1'b1;
            cas1_q  <= 1'b1;
            cas2_q  <= 1'b1;
            mux_q   <= 1'b0;
            busrq_q <= 1'b1;
            abe_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            cyc_q   <= cyc_d;
            burst_q <= burst_d;
            ras_q   <= ras_d;
            cas1_q  <= cas1_d;
            cas2_q  <= cas2_d;
            mux_q   <= mux_d;
            busrq_q <= busrq_d;
            abe_q   <= abe_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign RAS_N       = ras_q;
    assign CAS1_N      = cas1_q;
    assign CAS2_N      = cas2_q;
    assign MUX         = mux_q;
    assign BUSRQ_N     = busrq_q;
    assign ADDRBUFEN_N = abe_q;
    assign DMA_ACK     = ack_q;
    assign BUSY        = busy_q;

endmodule

// File: doc/mioc_dram_arbiter.md
Name: mioc_dram_arbiter

Overview:
Sequences the ADAM DRAM array and shares it between two requesters: the Z80 (memory and refresh cycles on the buffered bus) and the master 6801 DMA engine. It generates RAS_N/CAS1_N/CAS2_N/MUX and runs the BUSRQ_N/BUSAK_N handshake that takes the Z80 off the bus for DMA. It sits inside mioc_top between the buffered Z80 control inputs and the DRAM strobe pins.

Parameters:
T_CAS, 2, B_PHI cycles CAS is held low per DMA access (range 1..7)
MAX_BURST, 8, max DMA accesses per bus grant before a forced bus release (range 1..255)

Ports:
B_PHI  in  1  system clock; all state changes on the rising edge
RST_N  in  1  synchronous reset, active low
BMREQ_N  in  1  Z80 buffered memory request
BRFSH_N  in  1  Z80 buffered refresh
BA15  in  1  Z80 address bit 15; selects the bank for Z80 cycles (0 = CAS1_N, 1 = CAS2_N)
DMA_N  in  1  6801 DMA request, active-low level
DMA_BANK  in  1  bank for DMA accesses (0 = CAS1_N, 1 = CAS2_N)
BUSAK_N  in  1  Z80 bus acknowledge
BUSRQ_N  out  1  Z80 bus request
ADDRBUFEN_N  out  1  Z80 address buffer enable; high while the 6801 owns the bus
RAS_N  out  1  DRAM row strobe
CAS1_N  out  1  DRAM column strobe, bank 0
CAS2_N  out  1  DRAM column strobe, bank 1
MUX  out  1  DRAM address mux; 0 = row, 1 = column
DMA_ACK  out  1  single-cycle pulse in the last CAS cycle of each DMA access
BUSY  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered and are a function of the state only (Moore).
- Reset (RST_N low at a rising edge, in any state, including mid-cycle): next state is IDLE. Outputs: RAS_N=1, CAS1_N=1, CAS2_N=1, BUSRQ_N=1, MUX=0, ADDRBUFEN_N=0, DMA_ACK=0, BUSY=0. Counters clear.
- States: IDLE, Z_RAS, Z_CAS, REF, PRE, DMA_REQ, DMA_RAS, DMA_CAS, DMA_PRE, DMA_REL.
- IDLE priority, evaluated on the sampled inputs:
  1. BMREQ_N=0 and BRFSH_N=0 -> REF.
  2. BMREQ_N=0 and BRFSH_N=1 -> Z_RAS. Latch BA15 as the bank.
  3. DMA_N=0 -> DMA_REQ.
  4. Otherwise stay in IDLE.
- Z_RAS: RAS_N=0, MUX=0. Lasts 1 cycle, then Z_CAS.
- Z_CAS: RAS_N=0, MUX=1, CAS of the latched bank = 0. Stays while BMREQ_N=0. On BMREQ_N=1, go to PRE.
- REF: RAS_N=0, both CAS high, MUX=0 (RAS-only refresh). Stays while BMREQ_N=0. On BMREQ_N=1, go to PRE.
- PRE: all strobes high, MUX=0. Lasts 1 cycle, then IDLE. A new request is taken only from IDLE, so the minimum precharge is 1 cycle.
- DMA_REQ: BUSRQ_N=0.
  - BUSAK_N=0 and DMA_N=0: go to DMA_RAS, clear the burst counter, ADDRBUFEN_N goes 1.
  - DMA_N=1 and BUSAK_N=1 (request withdrawn): go to IDLE, BUSRQ_N returns to 1.
  - DMA_N=1 and BUSAK_N=0 in the same cycle: go to DMA_REL.
- DMA_RAS: BUSRQ_N=0, ADDRBUFEN_N=1, RAS_N=0, MUX=0. Lasts 1 cycle; latch DMA_BANK.
- DMA_CAS: RAS_N=0, MUX=1, CAS of the latched bank = 0, for exactly T_CAS cycles.
  - The 3-bit cycle counter counts from 0 to T_CAS-1.
  - DMA_ACK=1 only in the final cycle.
- DMA_PRE: strobes high, BUSRQ_N=0, ADDRBUFEN_N=1. Lasts 1 cycle; the burst counter increments. The burst counter is 8 bits wide and saturates at MAX_BURST.
  - DMA_N=0 and count < MAX_BURST: go to DMA_RAS.
  - Otherwise: go to DMA_REL.
- DMA_REL: BUSRQ_N=1, ADDRBUFEN_N=1, strobes high. Stay until BUSAK_N=1, then go to IDLE, where ADDRBUFEN_N=0.
  - A DMA request that is still pending is re-arbitrated in IDLE behind any Z80 request. This guarantees the Z80 at least one opportunity between bursts.
- Z80 inputs are ignored from DMA_REQ through DMA_REL, because the Z80 is off the bus once BUSAK_N=0.
- DMA_N deasserting mid-access (DMA_RAS/DMA_CAS) does not abort the access. The access completes, then the block releases the bus.
- BUSAK_N going high unexpectedly during DMA_RAS/DMA_CAS/DMA_PRE does not abort the access. The access completes, then the block goes to DMA_REL and exits at once.
- A DRAM strobe is never low in IDLE, PRE, DMA_REQ or DMA_REL. CAS1_N and CAS2_N are never both low.

Test Plan:
1. Reset mid-cycle: enter Z_CAS, assert RST_N=0 for 1 edge -> next cycle RAS_N=CAS1_N=CAS2_N=1, MUX=0, BUSRQ_N=1, ADDRBUFEN_N=0, BUSY=0.
2. Z80 read, BA15=1, BMREQ_N low for 4 cycles -> RAS_N low 1 cycle ahead of CAS2_N. MUX 0->1 with CAS. CAS1_N stays high. PRE follows for 1 cycle. BUSY low 2 cycles after BMREQ_N rises.
3. Refresh: BMREQ_N=0 and BRFSH_N=0 with DMA_N=0 simultaneously -> REF wins. RAS_N low, both CAS high. DMA_REQ is entered only after PRE.
4. Single DMA, BUSAK_N returned 3 cycles after BUSRQ_N falls, DMA_N released during CAS, DMA_BANK=0 -> ADDRBUFEN_N high on grant. CAS1_N low 2 cycles. DMA_ACK is 1 pulse. BUSRQ_N rises in DMA_REL. ADDRBUFEN_N low 1 cycle after BUSAK_N=1.
5. DMA burst with DMA_N held low, MAX_BURST=8 -> exactly 8 DMA_ACK pulses, 4 cycles apart (RAS, CAS, CAS, PRE). Then a forced release. A Z80 BMREQ_N pending at release is served before the next DMA_REQ.
6. Withdrawal: DMA_N low 1 cycle then high before BUSAK_N -> BUSRQ_N low 1 cycle, return to IDLE, no strobes. Withdrawal in the same cycle as BUSAK_N=0 -> DMA_REL, no RAS.
